// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment display blocks.
package display_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHOW0,
        BLANK0,
        SHOW1,
        BLANK1
    } scan_state_t;

    localparam logic ANODE_ON  = 1'b0;
    localparam logic ANODE_OFF = 1'b1;

    localparam int DEF_REFRESH_CNT = 100000;
    localparam int DEF_BLANK_CNT   = 2000;

    // Counter width able to hold the larger of the two dwell counts.
    function automatic int cnt_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Dwell counter: counts up from 0 after clear, flags done at the terminal value.
module scan_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         arst,
    input  logic         i_clear,
    input  logic [W-1:0] i_terminal,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    assign o_done = (r_cnt == i_terminal);

    // Holds at terminal so an unexpected extra cycle never wraps the count.
    always_ff @(posedge clk) begin
        if (arst || i_clear) begin
            r_cnt <= '0;
        end else if (!o_done) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Two-digit scan controller with dead-time blanking, frame-synchronous
// double-buffered digit updates and optional leading-zero suppression.
//
//   state  | meaning
//   IDLE   | display dark, waiting for en
//   SHOW0  | units anode lit, first cycle is the frame start
//   BLANK0 | both anodes off between units and tens
//   SHOW1  | tens anode lit (unless suppressed leading zero)
//   BLANK1 | both anodes off before the next frame
module digit_scan_ctrl
    import display_pkg::*;
#(
    parameter int REFRESH_CNT = DEF_REFRESH_CNT,
    parameter int BLANK_CNT   = DEF_BLANK_CNT,
    parameter int LZ_SUPPRESS = 1
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       en,
    input  logic [3:0] d_lo,
    input  logic [3:0] d_hi,
    input  logic       load,
    output logic [3:0] digit_out,
    output logic       AN0,
    output logic       AN1,
    output logic       blank,
    output logic       frame_start
);

    localparam int CW = cnt_width(REFRESH_CNT, BLANK_CNT);
    localparam logic [CW-1:0] T_SHOW  = CW'(REFRESH_CNT - 1);
    localparam logic [CW-1:0] T_BLANK = (BLANK_CNT > 0) ? CW'(BLANK_CNT - 1) : '0;

    scan_state_t r_state, w_state_nxt;

    logic [3:0] r_shadow_lo, r_shadow_hi;
    logic [3:0] r_active_lo, r_active_hi;
    logic       r_pending;

    logic [3:0] r_digit;
    logic       r_an0, r_an1, r_blank, r_frame_start;

    logic          w_done;
    logic          w_clear;
    logic [CW-1:0] w_terminal;
    logic          w_boundary;
    logic [3:0]    w_act_lo_nxt, w_act_hi_nxt;
    logic [3:0]    w_digit_nxt;
    logic          w_an0_nxt, w_an1_nxt;

    assign w_terminal = (r_state == BLANK0 || r_state == BLANK1) ? T_BLANK : T_SHOW;
    assign w_clear    = (w_state_nxt != r_state) || (r_state == IDLE);

    scan_timer #(.W(CW)) u_timer (
        .clk        (clk),
        .arst       (arst),
        .i_clear    (w_clear),
        .i_terminal (w_terminal),
        .o_done     (w_done)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (en) w_state_nxt = SHOW0;
            end
            SHOW0: begin
                if (!en)        w_state_nxt = IDLE;
                else if (w_done) begin
                    if (BLANK_CNT > 0) w_state_nxt = BLANK0;
                    else               w_state_nxt = SHOW1;
                end
            end
            BLANK0: begin
                if (!en)         w_state_nxt = IDLE;
                else if (w_done) w_state_nxt = SHOW1;
            end
            SHOW1: begin
                if (!en)        w_state_nxt = IDLE;
                else if (w_done) begin
                    if (BLANK_CNT > 0) w_state_nxt = BLANK1;
                    else               w_state_nxt = SHOW0;
                end
            end
            BLANK1: begin
                if (!en)         w_state_nxt = IDLE;
                else if (w_done) w_state_nxt = SHOW0;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // The active digits may only move on the cycle that enters SHOW0.
    assign w_boundary = (w_state_nxt == SHOW0) && (r_state != SHOW0);

    always_comb begin
        w_act_lo_nxt = r_active_lo;
        w_act_hi_nxt = r_active_hi;
        if (w_boundary) begin
            if (load) begin
                w_act_lo_nxt = d_lo;
                w_act_hi_nxt = d_hi;
            end else if (r_pending) begin
                w_act_lo_nxt = r_shadow_lo;
                w_act_hi_nxt = r_shadow_hi;
            end
        end
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        w_an0_nxt   = ANODE_OFF;
        w_an1_nxt   = ANODE_OFF;
        w_digit_nxt = r_digit;
        case (w_state_nxt)
            SHOW0: begin
                w_an0_nxt   = ANODE_ON;
                w_digit_nxt = w_act_lo_nxt;
            end
            SHOW1: begin
                w_digit_nxt = w_act_hi_nxt;
                if ((LZ_SUPPRESS != 0) && (w_act_hi_nxt == 4'd0)) w_an1_nxt = ANODE_OFF;
                else                                             w_an1_nxt = ANODE_ON;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            r_state       <= IDLE;
            r_shadow_lo   <= '0;
            r_shadow_hi   <= '0;
            r_active_lo   <= '0;
            r_active_hi   <= '0;
            r_pending     <= 1'b0;
            r_digit       <= '0;
            r_an0         <= ANODE_OFF;
            r_an1         <= ANODE_OFF;
            r_blank       <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_active_lo   <= w_act_lo_nxt;
            r_active_hi   <= w_act_hi_nxt;
            r_digit       <= w_digit_nxt;
            r_an0         <= w_an0_nxt;
            r_an1         <= w_an1_nxt;
            r_blank       <= (w_an0_nxt == ANODE_OFF) && (w_an1_nxt == ANODE_OFF);
            r_frame_start <= w_boundary;
            if (load) begin
                r_shadow_lo <= d_lo;
                r_shadow_hi <= d_hi;
            end
            if (w_boundary)  r_pending <= 1'b0;
            else if (load)   r_pending <= 1'b1;
        end
    end

    assign digit_out   = r_digit;
    assign AN0         = r_an0;
    assign AN1         = r_an1;
    assign blank       = r_blank;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Bench for digit_scan_ctrl: frame-position model plus directed literal checks.
module tb_digit_scan_ctrl;

    localparam int R     = 4;
    localparam int B     = 2;
    localparam int FRAME = 2 * (R + B);

    logic       clk;
    logic       arst, en, load;
    logic [3:0] d_lo, d_hi;

    logic [3:0] dig, nl_dig;
    logic       an0, an1, blk, fs;
    logic       nl_an0, nl_an1, nl_blk, nl_fs;

    digit_scan_ctrl #(.REFRESH_CNT(R), .BLANK_CNT(B), .LZ_SUPPRESS(1)) u_dut (
        .clk(clk), .arst(arst), .en(en), .d_lo(d_lo), .d_hi(d_hi), .load(load),
        .digit_out(dig), .AN0(an0), .AN1(an1), .blank(blk), .frame_start(fs)
    );

    digit_scan_ctrl #(.REFRESH_CNT(R), .BLANK_CNT(B), .LZ_SUPPRESS(0)) u_nl (
        .clk(clk), .arst(arst), .en(en), .d_lo(d_lo), .d_hi(d_hi), .load(load),
        .digit_out(nl_dig), .AN0(nl_an0), .AN1(nl_an1), .blank(nl_blk), .frame_start(nl_fs)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // model state: frame position rather than FSM state
    bit         m_run;
    int         m_pos;
    logic [3:0] m_sh_lo, m_sh_hi, m_act_lo, m_act_hi;
    bit         m_pend;
    logic [3:0] e_dig;
    logic       e_an0, e_an1, e_an1_nl, e_fs;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input int e_f, input int e_a0,
                           input int e_a1, input int e_b, input int e_d);
        check({tag, ".frame_start"}, fs, e_f);
        check({tag, ".AN0"}, an0, e_a0);
        check({tag, ".AN1"}, an1, e_a1);
        check({tag, ".blank"}, blk, e_b);
        check({tag, ".digit_out"}, dig, e_d);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_step();
        bit bnd;
        if (arst) begin
            m_run = 0; m_pos = 0; m_pend = 0;
            m_sh_lo = 0; m_sh_hi = 0; m_act_lo = 0; m_act_hi = 0;
            e_an0 = 1; e_an1 = 1; e_an1_nl = 1; e_dig = 0; e_fs = 0;
        end else begin
            bnd = 0;
            if (!m_run) begin
                if (en) begin m_run = 1; m_pos = 0; bnd = 1; end
            end else if (!en) begin
                m_run = 0;
            end else begin
                m_pos = (m_pos + 1) % FRAME;
                bnd = (m_pos == 0);
            end
            if (bnd && load) begin
                m_act_lo = d_lo; m_act_hi = d_hi; m_pend = 0;
            end else if (bnd && m_pend) begin
                m_act_lo = m_sh_lo; m_act_hi = m_sh_hi; m_pend = 0;
            end else if (load) begin
                m_sh_lo = d_lo; m_sh_hi = d_hi; m_pend = 1;
            end
            e_fs = bnd; e_an0 = 1; e_an1 = 1; e_an1_nl = 1;
            if (m_run) begin
                if (m_pos < R) begin
                    e_an0 = 0; e_dig = m_act_lo;
                end else if (m_pos >= R + B && m_pos < 2 * R + B) begin
                    e_dig = m_act_hi; e_an1 = (m_act_hi == 4'd0); e_an1_nl = 0;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("mdl.AN0", an0, e_an0);
            check("mdl.AN1", an1, e_an1);
            check("mdl.blank", blk, e_an0 & e_an1);
            check("mdl.digit_out", dig, e_dig);
            check("mdl.frame_start", fs, e_fs);
            check("mdl_nl.AN1", nl_an1, e_an1_nl);
            check("mdl_nl.blank", nl_blk, e_an0 & e_an1_nl);
            check("mdl_nl.digit_out", nl_dig, e_dig);
        end
    end

    initial begin
        arst = 1; en = 1; load = 1; d_lo = 9; d_hi = 9;
        // reset holds off scanning even with en and load high
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_en = 1'b1;
            chk_out("reset", 0, 1, 1, 1, 0);
        end
        arst = 0; en = 0; load = 0;
        tick();
        chk_out("idle", 0, 1, 1, 1, 0);

        // basic scan of 3/7
        d_hi = 3; d_lo = 7; load = 1;
        tick();
        load = 0; en = 1;
        tick();
        for (int i = 0; i <= 12; i++) begin
            case (i)
                0:       chk_out("scan_c0", 1, 0, 1, 0, 7);
                3:       chk_out("scan_c3", 0, 0, 1, 0, 7);
                4, 5:    chk_out("scan_blank0", 0, 1, 1, 1, 7);
                6, 9:    chk_out("scan_hi", 0, 1, 0, 0, 3);
                10, 11:  chk_out("scan_blank1", 0, 1, 1, 1, 3);
                12:      chk_out("scan_frame2", 1, 0, 1, 0, 7);
                default: ;
            endcase
            if (i < 12) tick();
        end

        // mid-frame load waits for the boundary
        repeat (6) tick();
        d_hi = 2; d_lo = 5; load = 1;
        tick();
        load = 0;
        chk_out("buf_old_hi", 0, 1, 0, 0, 3);
        repeat (5) tick();
        chk_out("buf_new_lo", 1, 0, 1, 0, 5);
        repeat (6) tick();
        chk_out("buf_new_hi", 0, 1, 0, 0, 2);

        // load exactly in the boundary cycle bypasses
        repeat (5) tick();
        d_hi = 4; d_lo = 8; load = 1;
        tick();
        load = 0;
        chk_out("bypass_lo", 1, 0, 1, 0, 8);
        repeat (6) tick();
        chk_out("bypass_hi", 0, 1, 0, 0, 4);

        // leading zero
        repeat (5) tick();
        d_hi = 0; d_lo = 5; load = 1;
        tick();
        load = 0;
        chk_out("lz_lo", 1, 0, 1, 0, 5);
        repeat (6) tick();
        chk_out("lz_hi", 0, 1, 1, 1, 0);
        check("nolz.AN1", nl_an1, 0);
        check("nolz.blank", nl_blk, 0);
        check("nolz.digit_out", nl_dig, 0);
        repeat (3) tick();
        chk_out("lz_hi_end", 0, 1, 1, 1, 0);

        // en dropped in second SHOW0 cycle
        repeat (3) tick();
        chk_out("en_start", 1, 0, 1, 0, 5);
        tick();
        en = 0;
        tick();
        chk_out("en_off", 0, 1, 1, 1, 5);
        en = 1;
        tick();
        chk_out("en_restart", 1, 0, 1, 0, 5);
        repeat (3) tick();
        chk_out("en_full_show0", 0, 0, 1, 0, 5);
        tick();
        chk_out("en_blank0", 0, 1, 1, 1, 5);

        // reset mid-SHOW1 discards a pending load
        repeat (2) tick();
        d_hi = 9; d_lo = 9; load = 1;
        tick();
        load = 0; arst = 1;
        tick();
        chk_out("rst_mid", 0, 1, 1, 1, 0);
        arst = 0;
        tick();
        chk_out("rst_lo", 1, 0, 1, 0, 0);
        repeat (6) tick();
        chk_out("rst_hi", 0, 1, 1, 1, 0);
        check("rst_nolz.AN1", nl_an1, 0);
        check("rst_nolz.digit_out", nl_dig, 0);
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/digit_scan_ctrl.md
Name: digit_scan_ctrl

Overview:
- Time-multiplexed scan controller for the two-digit seven-segment display.
- Consumes the two BCD nibbles from the binary-to-decimal stage and drives the nibble into the segment decoder, plus active-low anodes AN0/AN1.
- Replaces the free-running toggle plus mux pair with a counted scan that provides:
  - dead-time blanking between digits (anti-ghosting),
  - frame-synchronous double-buffered digit updates (no tearing),
  - optional leading-zero suppression.

Parameters:
- REFRESH_CNT, 100000: clk cycles each digit is lit (1 ms at 100 MHz); must be >= 1.
- BLANK_CNT, 2000: clk cycles both anodes are off after each digit; 0 removes the blank states.
- LZ_SUPPRESS, 1: 1 = do not light the tens digit when its value is 0.

Ports:
- clk  input  1  system clock
- arst  input  1  reset. Synchronous, active-high: sampled only on the rising edge of clk.
- en  input  1  scan enable; 0 = display dark
- d_lo  input  4  units digit (BCD, values 10-15 passed through unchanged)
- d_hi  input  4  tens digit
- load  input  1  one-cycle strobe; captures d_lo/d_hi into the shadow buffer
- digit_out  output  4  nibble to segment decoder
- AN0  output  1  units anode, active-low
- AN1  output  1  tens anode, active-low
- blank  output  1  1 while no anode is driven low
- frame_start  output  1  one-cycle pulse on entry to SHOW0

Behaviour:
- All outputs are registered and are Moore functions of the state register.
- Reset, when arst is sampled high:
  - state = IDLE, cnt = 0;
  - shadow_lo/hi, active_lo/hi, pending all = 0;
  - AN0 = AN1 = 1, digit_out = 0, blank = 1, frame_start = 0.
  - Reset has priority over en and load, including mid-frame. Any pending load is discarded.
- States: IDLE, SHOW0, BLANK0, SHOW1, BLANK1.
  - IDLE: AN0 = AN1 = 1, blank = 1. If en = 1, go to SHOW0 next cycle.
  - SHOW0: AN0 = 0, digit_out = active_lo. Stays REFRESH_CNT cycles, then goes to BLANK0 (or to SHOW1 if BLANK_CNT = 0).
  - BLANK0: both anodes 1, digit_out holds. Stays BLANK_CNT cycles, then SHOW1.
  - SHOW1: digit_out = active_hi. AN1 = 0, except AN1 = 1 when LZ_SUPPRESS = 1 and active_hi = 0. blank follows AN1. Stays REFRESH_CNT cycles, then BLANK1 (or SHOW0 if BLANK_CNT = 0).
  - BLANK1: both anodes 1. Stays BLANK_CNT cycles, then SHOW0.
- Dwell counter:
  - cnt is cleared on every state entry; a state is left when cnt reaches its dwell count minus 1.
  - Counter width = $clog2(max(REFRESH_CNT, BLANK_CNT) + 1).
  - Full frame = 2*(REFRESH_CNT + BLANK_CNT) cycles.
- en = 0 in any non-IDLE state:
  - next cycle is IDLE with anodes off;
  - cnt clears; shadow and pending are kept.
  - Re-enable always starts at a fresh, full-length SHOW0.
- Double buffering:
  - load = 1 writes d_lo/d_hi into the shadow registers and sets pending.
  - A later load before the frame boundary overwrites the shadow (last write wins).
  - Frame boundary = the cycle in which the FSM moves into SHOW0 (from BLANK1, from SHOW1 when BLANK_CNT = 0, or from IDLE).
  - At the boundary, if pending = 1 the active registers take the shadow values and pending clears.
  - If load = 1 in the boundary cycle itself, d_lo/d_hi bypass straight to the active registers and pending stays 0.
  - The active values never change in the middle of a frame.
- frame_start is high during the first SHOW0 cycle of each frame.

Decomposition:
- Shared package (display_pkg):
  - state enum (IDLE, SHOW0, BLANK0, SHOW1, BLANK1);
  - ANODE_ON = 1'b0 / ANODE_OFF = 1'b1 constants;
  - default REFRESH_CNT/BLANK_CNT constants.
- One sub-module: scan_timer, the dwell counter. It takes clk, arst, a clear input, a terminal value and a done output, and is reusable by the other display blocks.
- The FSM and double-buffer logic stay in digit_scan_ctrl.

Test Plan:
All scenarios use REFRESH_CNT = 4, BLANK_CNT = 2, LZ_SUPPRESS = 1 unless stated.
1. arst = 1 for 3 cycles with en = 1 and load = 1 -> AN0 = AN1 = 1, digit_out = 0, blank = 1, frame_start = 0 throughout; no scan starts until arst = 0.
2. load with d_hi = 3, d_lo = 7, then en = 1:
   - frame_start pulses;
   - AN0 = 0 with digit_out = 7 for 4 cycles;
   - blank for 2 cycles;
   - AN1 = 0 with digit_out = 3 for 4 cycles;
   - blank for 2 cycles;
   - frame_start repeats every 12 cycles.
3. d_hi = 0, d_lo = 5 -> AN1 stays 1 (blank = 1) for the whole SHOW1 slot. With LZ_SUPPRESS = 0, AN1 = 0 with digit_out = 0.
4. Running 3/7, then load 2/5 during SHOW1 -> rest of the frame still shows 3. The next SHOW0 shows 5 and the following SHOW1 shows 2. A load exactly in the boundary cycle is shown in that same SHOW0.
5. en dropped in the 2nd SHOW0 cycle -> next cycle AN0 = AN1 = 1. Re-asserting en gives a full 4-cycle SHOW0 with frame_start.
6. arst mid-SHOW1 with a pending load -> next cycle all reset values. After release with en = 1, both displayed digits are 0 (pending was discarded).
